// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: multi-push word buffer feeding a 5-state serialiser.
// Frame = start, DATA_W bits LSB first, optional parity, STOP_BITS stop bits; bit time = div_l+1 clocks.
module uart_tx_cfg #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4,
  parameter int N         = 4,
  parameter int DIV_W     = 16
)(
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [$clog2(N+1)-1:0]        push,
  input  logic [N-1:0][DATA_W-1:0]      data_i,
  output logic [$clog2(N+1)-1:0]        can_push,
  input  logic [DIV_W-1:0]              div,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          overflow
);
  localparam int PW = $clog2(N+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t state, state_n;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                rd_ptr, wr_ptr, wr_ptr_n;
  logic [N-1:0][AW-1:0]         lane_idx;
  logic [CW-1:0]                count, free;
  logic                         pop, wr_ok;

  logic [DIV_W-1:0]  cnt, div_l;
  logic [DATA_W-1:0] sh;
  logic              par_bit;
  logic [BW-1:0]     bit_idx;
  logic              stop_idx;
  logic              bit_end, last_data, last_stop;

  // Pointer sums never exceed 2*DEPTH-1, so one conditional subtract wraps them.
  function automatic logic [AW-1:0] wrap(input int p);
    return AW'((p >= DEPTH) ? p - DEPTH : p);
  endfunction

  // Free space counts the slot released by this cycle's pop.
  assign free     = CW'(DEPTH) - count + CW'(pop);
  assign can_push = (free >= CW'(N)) ? PW'(N) : PW'(free);
  assign wr_ok    = (push <= can_push);
  assign wr_ptr_n = wrap(int'(wr_ptr) + int'(push));

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      assign lane_idx[i] = wrap(int'(wr_ptr) + i);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (wr_ok && i < int'(push)) mem[lane_idx[i]] <= data_i[i];
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)   rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      if (wr_ok) wr_ptr <= wr_ptr_n;
      count    <= count - CW'(pop) + (wr_ok ? CW'(push) : '0);
      overflow <= !wr_ok;
    end
  end

  assign bit_end   = (cnt == '0);
  assign last_data = (bit_idx == BW'(DATA_W-1));
  assign last_stop = (stop_idx == 1'(STOP_BITS-1));

  always_ff @(posedge clk) begin
    if (!arstn) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (tx_en && count != '0) state_n = S_START;
      S_START: if (bit_end) state_n = S_DATA;
      S_DATA:  if (bit_end && last_data) state_n = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (bit_end) state_n = S_STOP;
      S_STOP:  if (bit_end && last_stop) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    busy    = (state != S_IDLE);
    tx_done = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE:  pop     = tx_en && (count != '0);
      S_START: tx      = 1'b0;
      S_DATA:  tx      = sh[0];
      S_PAR:   tx      = par_bit;
      S_STOP:  tx_done = bit_end && last_stop;
      default: ;
    endcase
  end

  // Divisor is sampled at pop so a mid-frame change only affects the next frame.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      cnt      <= '0;
      div_l    <= '0;
      sh       <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (pop) begin
      sh       <= mem[rd_ptr];
      div_l    <= div;
      cnt      <= div;
      par_bit  <= (PARITY == 2) ? ~(^mem[rd_ptr]) : ^mem[rd_ptr];
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        cnt <= div_l;
        if (state == S_DATA) begin
          sh      <= sh >> 1;
          bit_idx <= bit_idx + BW'(1);
        end
        if (state == S_STOP) stop_idx <= ~stop_idx;
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four instances (no parity, even, odd, two stop bits) share stimulus;
// sel picks the instance whose outputs are checked.
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic arstn;
  logic [2:0] push;
  logic [3:0][7:0] data_i;
  logic [15:0] div;
  logic tx_en;
  logic [3:0] tx_w, busy_w, done_w, ovf_w;
  logic [3:0][2:0] cp_w;
  logic tx_m, busy_m, done_m, ovf_m;
  logic [2:0] cp_m;
  logic [1:0] sel;
  int n_cmp = 0;
  int n_err = 0;
  int w, bad;

  always #5 clk = ~clk;

  uart_tx_cfg #(.PARITY(0), .STOP_BITS(1)) u_a (.clk(clk), .arstn(arstn), .push(push), .data_i(data_i),
    .can_push(cp_w[0]), .div(div), .tx_en(tx_en), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]), .overflow(ovf_w[0]));
  uart_tx_cfg #(.PARITY(1), .STOP_BITS(1)) u_e (.clk(clk), .arstn(arstn), .push(push), .data_i(data_i),
    .can_push(cp_w[1]), .div(div), .tx_en(tx_en), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]), .overflow(ovf_w[1]));
  uart_tx_cfg #(.PARITY(2), .STOP_BITS(1)) u_o (.clk(clk), .arstn(arstn), .push(push), .data_i(data_i),
    .can_push(cp_w[2]), .div(div), .tx_en(tx_en), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]), .overflow(ovf_w[2]));
  uart_tx_cfg #(.PARITY(0), .STOP_BITS(2)) u_s (.clk(clk), .arstn(arstn), .push(push), .data_i(data_i),
    .can_push(cp_w[3]), .div(div), .tx_en(tx_en), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]), .overflow(ovf_w[3]));

  always_comb begin
    tx_m   = tx_w[sel];
    busy_m = busy_w[sel];
    done_m = done_w[sel];
    ovf_m  = ovf_w[sel];
    cp_m   = cp_w[sel];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    push  = '0;
    @(negedge clk);
    arstn = 1'b1;
  endtask

  // Counts clocks where the line is not idle over ncyc clocks.
  task automatic quiet(input int ncyc, output int nbad);
    nbad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) nbad++;
    end
  endtask

  // Waits for a start bit, then checks every clock of the frame and the idle clock after it.
  // pb < 0: no parity bit. act 1 drops tx_en, act 2 sets div=7, at frame clock act_at.
  task automatic expect_frame(input string tag, input logic [7:0] d, input int pb, input int stops,
                              input int dv, input int act, input int act_at, output int waited);
    int total, slot, bad_tx, bad_busy, bad_done;
    logic e;
    logic [31:0] pbv;
    total = (1 + 8 + ((pb >= 0) ? 1 : 0) + stops) * (dv + 1);
    pbv = pb;
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    waited = 0;
    while (tx_m !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_start_seen"}, (waited < 400) ? 1 : 0, 1);
    if (waited >= 400) return;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge clk);
      slot = k / (dv + 1);
      if (slot == 0)                    e = 1'b0;
      else if (slot <= 8)               e = d[slot-1];
      else if (pb >= 0 && slot == 9)    e = pbv[0];
      else                              e = 1'b1;
      if (tx_m !== e) bad_tx++;
      if (busy_m !== 1'b1) bad_busy++;
      if (done_m !== (k == total - 1)) bad_done++;
      if (k == act_at) begin
        if (act == 1) tx_en = 1'b0;
        if (act == 2) div = 16'd7;
      end
    end
    @(negedge clk);
    chk({tag, "_tx_bits"}, bad_tx, 0);
    chk({tag, "_busy"}, bad_busy, 0);
    chk({tag, "_done_pulse"}, bad_done, 0);
    chk({tag, "_idle_after"}, {tx_m, busy_m}, 2'b10);
  endtask

  initial begin
    sel = 2'd0; arstn = 1'b0; push = '0; data_i = '0; div = 16'd3; tx_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx_m, 1);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_ovf", ovf_m, 0);
    chk("rst_can_push", cp_m, 4);
    arstn = 1'b1;

    // 0xA5, 8N1, 40-clock frame
    data_i[0] = 8'hA5; push = 3'd1;
    @(negedge clk); push = '0;
    expect_frame("t1", 8'hA5, -1, 1, 3, 0, -1, w);
    chk("t1_latency", w, 1);

    // 0x07 with even then odd parity
    sel = 2'd1; do_reset();
    data_i[0] = 8'h07; push = 3'd1;
    @(negedge clk); push = '0;
    expect_frame("t2e", 8'h07, 1, 1, 3, 0, -1, w);
    sel = 2'd2; do_reset();
    push = 3'd1;
    @(negedge clk); push = '0;
    expect_frame("t2o", 8'h07, 0, 1, 3, 0, -1, w);

    // four words in one push, two stop bits, back-to-back
    sel = 2'd3; do_reset();
    data_i = {8'h04, 8'h03, 8'h02, 8'h01}; push = 3'd4;
    @(negedge clk); push = '0;
    for (int f = 1; f <= 4; f++) begin
      expect_frame("t3", 8'(f), -1, 2, 3, 0, -1, w);
      chk("t3_gap", w, 1);
    end

    // full buffer rejects a push
    sel = 2'd0; do_reset();
    tx_en = 1'b0;
    data_i = {8'h44, 8'h33, 8'h22, 8'h11}; push = 3'd4;
    @(negedge clk);
    chk("t4_full_cp", cp_m, 0);
    data_i = {4{8'hEE}}; push = 3'd2;
    @(negedge clk); push = '0;
    chk("t4_ovf_pulse", ovf_m, 1);
    chk("t4_cp_still0", cp_m, 0);
    @(negedge clk);
    chk("t4_ovf_clear", ovf_m, 0);
    tx_en = 1'b1;
    #1 chk("t4_cp_after_pop", cp_m, 1);
    expect_frame("t4a", 8'h11, -1, 1, 3, 0, -1, w);
    expect_frame("t4b", 8'h22, -1, 1, 3, 0, -1, w);
    expect_frame("t4c", 8'h33, -1, 1, 3, 0, -1, w);
    expect_frame("t4d", 8'h44, -1, 1, 3, 0, -1, w);
    chk("t4_gap", w, 1);

    // tx_en gating
    do_reset();
    tx_en = 1'b0;
    data_i = {16'h0, 8'hC3, 8'h3C}; push = 3'd2;
    @(negedge clk); push = '0;
    quiet(20, bad);
    chk("t5_hold_idle", bad, 0);
    tx_en = 1'b1;
    expect_frame("t5a", 8'h3C, -1, 1, 3, 1, 10, w);
    chk("t5_en_latency", w, 1);
    quiet(20, bad);
    chk("t5_second_waits", bad, 0);
    chk("t5_cp_one_left", cp_m, 3);
    tx_en = 1'b1;
    expect_frame("t5b", 8'hC3, -1, 1, 3, 0, -1, w);
    chk("t5b_latency", w, 1);

    // divisor change mid-frame, then reset mid-frame
    do_reset();
    data_i = {16'h0, 8'h69, 8'h96}; push = 3'd2;
    @(negedge clk); push = '0;
    expect_frame("t6a", 8'h96, -1, 1, 3, 2, 10, w);
    expect_frame("t6b", 8'h69, -1, 1, 7, 0, -1, w);
    chk("t6_gap", w, 1);
    data_i = {16'h0, 8'h3C, 8'h5A}; push = 3'd2;
    @(negedge clk); push = '0;
    w = 0;
    while (tx_m !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("t6_third_start", w, 1);
    repeat (10) @(negedge clk);
    arstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_tx", tx_m, 1);
    chk("t6_rst_busy", busy_m, 0);
    chk("t6_rst_done", done_m, 0);
    chk("t6_rst_cp", cp_m, 4);
    arstn = 1'b1;
    quiet(100, bad);
    chk("t6_fifo_flushed", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
